// File: rtl/cdb_bus.sv
// cdb_bus: multi-channel result broadcast bus.
// Buffers tagged results from NCH producers in per-channel FIFOs and drives
// one winner per cycle onto a registered valid/ready broadcast output, chosen
// by round-robin arbitration.
//
// Optional feature macro: CDB_BUS_BYPASS_EN
//   defined   - an empty channel with in_valid=1 competes in the same cycle and,
//               if it wins, skips its FIFO (1-edge latency)
//   undefined - every result passes through its FIFO (2-edge minimum latency)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous discard of all buffered and output results
//   in_valid   [NCH]          producer i offers a result
//   in_ready   [NCH]          channel i FIFO not full (from registered count)
//   in_data    [NCH*DATA_W]   packed payloads, channel i at slice i
//   in_tag     [NCH*TAG_W]    packed tags, channel i at slice i
//   out_valid  broadcast result present
//   out_ready  consumer accepts broadcast
//   out_data   broadcast payload (0 when idle)
//   out_tag    broadcast tag (0 when idle)
//   out_ch     source channel of broadcast (0 when idle)

module cdb_bus #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned NCH    = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [NCH-1:0]                          in_valid,
    output logic [NCH-1:0]                          in_ready,
    input  logic [NCH*DATA_W-1:0]                   in_data,
    input  logic [NCH*TAG_W-1:0]                    in_tag,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DATA_W-1:0]                       out_data,
    output logic [TAG_W-1:0]                        out_tag,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned ENT_W = DATA_W + TAG_W;

    // FIFO storage and bookkeeping, one set per channel
    logic [ENT_W-1:0] mem   [NCH][DEPTH];
    logic [PTR_W-1:0] wptr  [NCH];
    logic [PTR_W-1:0] rptr  [NCH];
    logic [CNT_W-1:0] count [NCH];
    logic [CH_W-1:0]  rr;

    logic             load_c;
    logic [NCH-1:0]   cand_c;
    logic [NCH-1:0]   push_c;
    logic [NCH-1:0]   pop_c;
    logic [NCH-1:0]   byp_c;
    logic             found_c;
    logic [CH_W-1:0]  win_c;
    logic [CH_W-1:0]  rr_next_c;
    logic [ENT_W-1:0] win_ent_c;

    // Output register may take a new value when empty or being consumed
    assign load_c = !out_valid || out_ready;

    // Space check uses the registered count only, so a full FIFO refuses a
    // push even in a cycle where it also pops
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = (count[i] != CNT_W'(DEPTH));
        end
    end

    // Arbitration candidates
    always_comb begin
        cand_c = '0;
        for (int i = 0; i < NCH; i++) begin
`ifdef CDB_BUS_BYPASS_EN
            cand_c[i] = (count[i] != '0) || in_valid[i];
`else
            cand_c[i] = (count[i] != '0);
`endif
        end
    end

    // Round-robin search starting at rr, wrapping at NCH
    always_comb begin
        int idx;
        found_c = 1'b0;
        win_c   = '0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr) + k;
            if (idx >= int'(NCH)) begin
                idx = idx - int'(NCH);
            end
            for (int j = 0; j < NCH; j++) begin
                if (!found_c && (j == idx) && cand_c[j]) begin
                    found_c = 1'b1;
                    win_c   = CH_W'(j);
                end
            end
        end
    end

    // Pointer following the winner
    always_comb begin
        int nxt;
        nxt = int'(win_c) + 1;
        if (nxt >= int'(NCH)) begin
            nxt = 0;
        end
        rr_next_c = CH_W'(nxt);
    end

    // Winner entry selection: FIFO head, or the raw input when bypassing
    always_comb begin
        pop_c     = '0;
        byp_c     = '0;
        win_ent_c = '0;
        for (int i = 0; i < NCH; i++) begin
            if (load_c && found_c && (win_c == CH_W'(i))) begin
                if (count[i] != '0) begin
                    pop_c[i]  = 1'b1;
                    win_ent_c = mem[i][rptr[i]];
                end
`ifdef CDB_BUS_BYPASS_EN
                else begin
                    byp_c[i]  = 1'b1;
                    win_ent_c = {in_data[i*DATA_W +: DATA_W], in_tag[i*TAG_W +: TAG_W]};
                end
`endif
            end
        end
    end

    // Accepted pushes; a bypassed input never enters its FIFO
    always_comb begin
        push_c = '0;
        for (int i = 0; i < NCH; i++) begin
            push_c[i] = in_valid[i] && in_ready[i] && !byp_c[i];
        end
    end

    // FIFO payload storage (no reset needed: validity lives in count)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push_c[i] && !flush) begin
                mem[i][wptr[i]] <= {in_data[i*DATA_W +: DATA_W], in_tag[i*TAG_W +: TAG_W]};
            end
        end
    end

    // FIFO pointers and counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NCH; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push_c[i]) begin
                    wptr[i] <= wptr[i] + PTR_W'(1);
                end
                if (pop_c[i]) begin
                    rptr[i] <= rptr[i] + PTR_W'(1);
                end
                if (push_c[i] && !pop_c[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (pop_c[i] && !push_c[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    // Broadcast register and round-robin pointer (rr survives flush)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_ch    <= '0;
            rr        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_ch    <= '0;
        end else if (load_c) begin
            out_valid <= found_c;
            out_data  <= found_c ? win_ent_c[ENT_W-1:TAG_W] : '0;
            out_tag   <= found_c ? win_ent_c[TAG_W-1:0] : '0;
            out_ch    <= found_c ? win_c : '0;
            if (found_c) begin
                rr <= rr_next_c;
            end
        end
    end

endmodule

// File: tb/tb_cdb_bus.sv
// Scoreboard bench for cdb_bus (NCH=2, DEPTH=4, DATA_W=32, TAG_W=3).
// Directed stimulus pushes hand-computed expected beats into a queue; a
// negedge monitor pops and compares every accepted broadcast.

module tb_cdb_bus;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned NCH    = 2;
    localparam int unsigned DEPTH  = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  tag;
        logic        ch;
    } beat_t;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*DATA_W-1:0] in_data;
    logic [NCH*TAG_W-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic [TAG_W-1:0]     out_tag;
    logic [0:0]           out_ch;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];

    cdb_bus #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .NCH(NCH), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_ch(out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [2:0] t, input logic c);
        beat_t b;
        b.data = d;
        b.tag  = t;
        b.ch   = c;
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) begin
            tick();
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Monitor: every accepted broadcast must match the queue head
    always @(negedge clk) begin
        if (rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h tag %0h ch %0d expected none (t=%0t)",
                         out_data, out_tag, out_ch, $time);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", 64'(out_data), 64'(e.data));
                chk("beat_tag",  64'(out_tag),  64'(e.tag));
                chk("beat_ch",   64'(out_ch),   64'(e.ch));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        // Reset and idle
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_ch",    64'(out_ch),    64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd3);
        rst = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready),  64'd3);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // Single push on ch1
        out_ready = 1'b1;
        in_valid  = 2'b10;
        in_data   = {32'hDEADBEEF, 32'h0};
        in_tag    = {3'd5, 3'd0};
        expect_beat(32'hDEADBEEF, 3'd5, 1'b1);
        tick();
        in_valid = '0;
`ifdef CDB_BUS_BYPASS_EN
        chk("single_lat1_valid", 64'(out_valid), 64'd1);
`else
        chk("single_lat1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("single_lat2_valid", 64'(out_valid), 64'd1);
`endif
        chk("single_data", 64'(out_data), 64'hDEADBEEF);
        tick();
        chk("single_after_valid", 64'(out_valid), 64'd0);
        chk("single_after_data",  64'(out_data),  64'd0);
        chk("single_queue", 64'(exp_q.size()), 64'd0);

        // Fairness: prefill both channels, then release the consumer
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 2'b11;
            in_data  = {32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
            in_tag   = {3'(4 + i), 3'(i)};
            tick();
        end
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            expect_beat(32'h1000_0000 + 32'(i), 3'(i), 1'b0);
            expect_beat(32'h2000_0000 + 32'(i), 3'(4 + i), 1'b1);
        end
        tick(); tick();
        chk("fair_head_valid", 64'(out_valid), 64'd1);
        chk("fair_head_tag",   64'(out_tag),   64'd0);
        chk("fair_head_ch",    64'(out_ch),    64'd0);
        out_ready = 1'b1;
        wait_drain(40);
        chk("fair_idle", 64'(out_valid), 64'd0);

        // Full and backpressure on ch0: one entry held in output, four buffered
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 2'b01;
            in_data  = {32'h0, 32'hA000_0000 + 32'(i)};
            in_tag   = {3'd0, 3'(1 + i)};
            expect_beat(32'hA000_0000 + 32'(i), 3'(1 + i), 1'b0);
            tick();
        end
        in_data = {32'h0, 32'hBAD0_0000};
        in_tag  = {3'd0, 3'd7};
        chk("full_in_ready0", 64'(in_ready[0]), 64'd0);
        chk("full_in_ready1", 64'(in_ready[1]), 64'd1);
        chk("stall_data_a",   64'(out_data),    64'hA000_0000);
        tick();
        chk("stall_data_b",   64'(out_data),    64'hA000_0000);
        chk("stall_tag_b",    64'(out_tag),     64'd1);
        chk("stall_ready_b",  64'(in_ready[0]), 64'd0);
        // Consumer resumes while full: the push this cycle must still be refused
        out_ready = 1'b1;
        chk("full_pop_ready", 64'(in_ready[0]), 64'd0);
        tick();
        in_valid = '0;
        wait_drain(40);
        tick(); tick();
        chk("full_idle", 64'(out_valid), 64'd0);

        // Flush with three buffered entries and a held output
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 2'b10;
            in_data  = {32'hC000_0000 + 32'(i), 32'h0};
            in_tag   = {3'(i), 3'd0};
            tick();
        end
        chk("preflush_valid", 64'(out_valid), 64'd1);
        chk("preflush_ready", 64'(in_ready),  64'd3);
        flush    = 1'b1;
        in_valid = 2'b01;
        in_data  = {32'h0, 32'hF00D_F00D};
        in_tag   = {3'd0, 3'd6};
        tick();
        flush    = 1'b0;
        in_valid = '0;
        chk("flush_valid",    64'(out_valid), 64'd0);
        chk("flush_data",     64'(out_data),  64'd0);
        chk("flush_in_ready", 64'(in_ready),  64'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("postflush_valid", 64'(out_valid), 64'd0);

        // Async reset in the middle of a burst on ch0
        for (int i = 0; i < 4; i++) begin
            expect_beat(32'hE000_0000 + 32'(i), 3'(1 + i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 2'b01;
            in_data  = {32'h0, 32'hE000_0000 + 32'(i)};
            in_tag   = {3'd0, 3'(1 + i)};
            tick();
        end
        chk("burst_valid", 64'(out_valid), 64'd1);
        #3;
        rst      = 1'b0;
        in_valid = '0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data",  64'(out_data),  64'd0);
        chk("async_rst_ready", 64'(in_ready),  64'd3);
        exp_q.delete();
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("postrst_valid", 64'(out_valid), 64'd0);
        chk("postrst_ready", 64'(in_ready),  64'd3);
        chk("final_queue",   64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
